// File: rtl/addsub_acc_pipe.sv
// addsub_acc_pipe: 2-stage signed ADD/SUB/ADD3/ACC unit; in: clk rst in_valid op in_clr a b c out_ready; out: in_ready out_valid res ovf acc
module addsub_acc_pipe #(
  parameter int N = 4,
  parameter int ACC_W = 8,
  parameter int SAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             in_clr,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] res,
  output logic             ovf,
  output logic [ACC_W-1:0] acc
);
  localparam logic [1:0] ADD3 = 2'b10, ACC = 2'b11;
  logic             en, s1_valid, s1_clr, t_ovf;
  logic [1:0]       s1_op;
  logic [N-1:0]     s1_c;
  logic [N:0]       s1_d, d_in;
  logic [ACC_W-1:0] d_x, c_x, base, sat_val, acc_nxt, res_nxt;
  logic [ACC_W:0]   t;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  assign d_in = op[0] ? {a[N-1], a} - {b[N-1], b} : {a[N-1], a} + {b[N-1], b};
  assign d_x = {{(ACC_W-N-1){s1_d[N]}}, s1_d};
  assign c_x = {{(ACC_W-N){s1_c[N-1]}}, s1_c};
  assign base = s1_clr ? '0 : acc;
  assign t = {base[ACC_W-1], base} + {d_x[ACC_W-1], d_x};
  assign t_ovf = t[ACC_W] ^ t[ACC_W-1];
  assign sat_val = t[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  assign acc_nxt = (SAT != 0 && t_ovf) ? sat_val : t[ACC_W-1:0];
  assign res_nxt = s1_op == ACC ? acc_nxt : s1_op == ADD3 ? d_x + c_x : d_x;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_clr    <= 1'b0;
      s1_c      <= '0;
      s1_d      <= '0;
      out_valid <= 1'b0;
      res       <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_op  <= op;
        s1_clr <= in_clr;
        s1_c   <= c;
        s1_d   <= d_in;
      end
      if (s1_valid) begin
        res <= res_nxt;
        ovf <= s1_op == ACC && t_ovf;
        if (s1_op == ACC) acc <= acc_nxt;
      end
    end
endmodule

// File: tb/tb_addsub_acc_pipe.sv
// tb_addsub_acc_pipe: wrapping and saturating instances driven in lockstep, scoreboarded against an integer model
module tb_addsub_acc_pipe;
  localparam int N = 4, W = 8, LIM = 1 << (W - 1);
  typedef struct {int r0, r1, o0, o1, a0, a1;} exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_clr = 0, out_ready = 1;
  logic [1:0] op = 0;
  logic [N-1:0] a = 0, b = 0, c = 0;
  logic in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
  logic [W-1:0] res0, res1, acc0, acc1;
  int errors = 0, checks = 0;
  int macc[2];
  exp_t q[$];
  logic last_ov;
  addsub_acc_pipe #(.N(N), .ACC_W(W), .SAT(0)) dut0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .op(op), .in_clr(in_clr), .a(a), .b(b), .c(c), .out_valid(out_valid0), .out_ready(out_ready), .res(res0), .ovf(ovf0), .acc(acc0));
  addsub_acc_pipe #(.N(N), .ACC_W(W), .SAT(1)) dut1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .in_clr(in_clr), .a(a), .b(b), .c(c), .out_valid(out_valid1), .out_ready(out_ready), .res(res1), .ovf(ovf1), .acc(acc1));
  initial forever #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int wrap(input int t);
    return ((t + LIM) & (2 * LIM - 1)) - LIM;
  endfunction
  function automatic int sv(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction
  task automatic push();
    exp_t e;
    int sa, sb, sc, t;
    int r[2], o[2];
    sa = int'($signed(a));
    sb = int'($signed(b));
    sc = int'($signed(c));
    for (int s = 0; s < 2; s++) begin
      o[s] = 0;
      if (op == 2'b00) r[s] = sa + sb;
      else if (op == 2'b01) r[s] = sa - sb;
      else if (op == 2'b10) r[s] = sa + sb + sc;
      else begin
        t = (in_clr ? 0 : macc[s]) + sa - sb;
        o[s] = (t >= LIM || t < -LIM) ? 1 : 0;
        r[s] = s == 0 ? wrap(t) : (t >= LIM ? LIM - 1 : (t < -LIM ? -LIM : t));
        macc[s] = r[s];
      end
    end
    e.r0 = r[0]; e.r1 = r[1]; e.o0 = o[0]; e.o1 = o[1]; e.a0 = macc[0]; e.a1 = macc[1];
    q.push_back(e);
  endtask
  task automatic step(output logic took);
    exp_t e;
    #1;
    last_ov = out_valid0;
    chk("sat_valid_track", int'(out_valid1), int'(out_valid0));
    if (out_valid0 && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("res_wrap", sv(res0), e.r0);
        chk("res_sat", sv(res1), e.r1);
        chk("ovf_wrap", int'(ovf0), e.o0);
        chk("ovf_sat", int'(ovf1), e.o1);
        chk("acc_wrap", sv(acc0), e.a0);
        chk("acc_sat", sv(acc1), e.a1);
      end
    end
    took = in_valid && in_ready0;
    if (took) push();
    @(negedge clk);
  endtask
  task automatic send(input logic [1:0] o, input int x, input int y, input int z, input logic cl);
    logic took;
    int k;
    op = o; a = x[N-1:0]; b = y[N-1:0]; c = z[N-1:0]; in_clr = cl; in_valid = 1;
    k = 0;
    do begin
      step(took);
      k++;
    end while (!took && k < 20);
    if (!took) chk("accept_timeout", 0, 1);
  endtask
  task automatic idle(input int n);
    logic took;
    in_valid = 0;
    for (int i = 0; i < n; i++) step(took);
  endtask
  initial begin
    int lat;
    logic [2:0] pat;
    logic [W-1:0] held;
    logic took;
    macc[0] = 0; macc[1] = 0;
    #2;
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_in_ready", int'(in_ready0), 1);
    chk("rst_res", sv(res0), 0);
    chk("rst_acc", sv(acc0), 0);
    chk("rst_ovf", int'(ovf0), 0);
    @(negedge clk);
    rst = 0;
    send(2'b00, 7, 1, 0, 0);
    in_valid = 0;
    lat = 0;
    do begin
      step(took);
      lat++;
    end while (!last_ov && lat < 6);
    chk("latency", lat, 2);
    idle(2);
    send(2'b01, -8, 7, 0, 0);
    send(2'b10, 0, 2, -1, 0);
    in_valid = 0;
    for (int i = 2; i >= 0; i--) begin
      step(took);
      pat[i] = last_ov;
    end
    chk("b2b_valid", int'(pat), 3'b110);
    send(2'b11, 7, -8, 0, 1);
    for (int i = 0; i < 8; i++) send(2'b11, 7, -8, 0, 0);
    idle(3);
    chk("acc9_wrap", sv(acc0), -121);
    chk("acc9_sat", sv(acc1), 127);
    chk("ovf9_wrap", int'(ovf0), 1);
    chk("ovf9_sat", int'(ovf1), 1);
    out_ready = 0;
    send(2'b00, 1, 2, 0, 0);
    send(2'b01, 3, 1, 0, 0);
    in_valid = 1;
    held = res0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", int'(in_ready0), 0);
      chk("stall_out_valid", int'(out_valid0), 1);
      chk("stall_res", sv(res0), sv(held));
      step(took);
      chk("stall_no_accept", int'(took), 0);
    end
    out_ready = 1;
    idle(4);
    chk("stall_drain", q.size(), 0);
    send(2'b11, 3, 1, 0, 1);
    send(2'b11, 2, -1, 0, 0);
    send(2'b00, 1, 1, 0, 0);
    idle(3);
    chk("add_keeps_acc", sv(acc0), 5);
    send(2'b11, -8, 7, 0, 1);
    idle(3);
    chk("clr_acc", sv(acc0), -15);
    send(2'b11, 5, 1, 0, 0);
    send(2'b00, 3, 3, 0, 0);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_out_valid", int'(out_valid0), 0);
    chk("arst_acc", sv(acc0), 0);
    chk("arst_res", sv(res0), 0);
    chk("arst_in_ready", int'(in_ready0), 1);
    rst = 0;
    q.delete();
    macc[0] = 0; macc[1] = 0;
    @(negedge clk);
    send(2'b11, 2, 5, 0, 0);
    idle(3);
    chk("post_rst_acc", sv(acc0), -3);
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      op = 2'($urandom);
      a = N'($urandom);
      b = N'($urandom);
      c = N'($urandom);
      in_clr = ($urandom % 5) == 0;
      step(took);
    end
    out_ready = 1;
    idle(5);
    chk("final_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
